uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 42 ++++
 rtl/uart_tx_shifter.sv | 108 ++++++++++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: frame state
// encoding, data width, round-robin winner search and even parity.
package uart_arb_pkg;

    localparam int DATA_BITS = 8;
    localparam int MAX_REQ   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } tx_state_e;

    // Search valid[] from ptr upward, wrapping at n. Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [3:0] res;
        logic [2:0] idx3;
        int         idx;
        res = 4'b0000;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx  = (int'(ptr) + k) % n;
            idx3 = idx[2:0];
            if ((k < n) && (res[3] == 1'b0) && valid[idx3]) begin
                res = {1'b1, idx3};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Serialises one latched byte as start / 8 data bits LSB first / stop,
// every bit aligned to baud_tick. Optional macro UART_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module uart_tx_shifter
    import uart_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_byte,
    input  logic                 baud_tick,
`ifdef UART_PARITY_EN
    input  logic                 parity,
`endif
    output logic                 tx,
    output logic                 done
);

    tx_state_e            state_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic [2:0]           bit_cnt_r;
    logic                 tx_r;
`ifdef UART_PARITY_EN
    logic                 par_r;
`endif

    // done marks the tick that ends the stop bit, so the owner can drop
    // busy on the same edge the frame FSM returns to IDLE.
    assign done = (state_r == STOP) && baud_tick;
    assign tx   = tx_r;

    // Frame sequencer: a load arms WAIT_TICK (a tick in the load cycle is
    // ignored), then each tick advances one bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= 3'd0;
            tx_r      <= 1'b1;
`ifdef UART_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (load) begin
                        shreg_r   <= data_byte;
                        bit_cnt_r <= 3'd0;
`ifdef UART_PARITY_EN
                        par_r     <= parity;
`endif
                        state_r   <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (baud_tick) begin
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_r    <= shreg_r[0];
                        shreg_r <= {1'b0, shreg_r[DATA_BITS-1:1]};
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_r    <= par_r;
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            tx_r      <= shreg_r[0];
                            shreg_r   <= {1'b0, shreg_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        tx_r    <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between NUM_REQ byte
// streams, with a packet lock that keeps multi-byte packets contiguous.
// Optional macro UART_PARITY_EN selects 8E1 framing instead of 8N1.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 locked,
    output logic [ID_W-1:0]      grant_id
);

    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    grant_id_r;
    logic               locked_r;
    logic               busy_r;
    logic [3:0]         pick_s;
    logic [ID_W-1:0]    win_s;
    logic               grant_ok_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [7:0]         sel_byte_s;
    logic               sel_last_s;
    logic               accept_s;
    logic [ID_W-1:0]    next_ptr_s;
    logic               tx_s;
    logic               done_s;

    // Winner selection: while locked only the owner is eligible.
    always_comb begin
        pick_s = rr_pick(8'(req_valid), 3'(ptr_r), NUM_REQ);
        if (locked_r) begin
            win_s      = grant_id_r;
            grant_ok_s = req_valid[grant_id_r];
        end else begin
            win_s      = ID_W'(pick_s[2:0]);
            grant_ok_s = pick_s[3];
        end
    end

    // One-hot ready strobe (only while the line is idle) and data mux.
    always_comb begin
        ready_s    = {NUM_REQ{1'b0}};
        sel_byte_s = 8'h00;
        sel_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == ID_W'(i)) begin
                sel_byte_s = req_data[8*i +: 8];
                sel_last_s = req_last[i];
                ready_s[i] = grant_ok_s & ~busy_r & ~rst;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (win_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = win_s + ID_W'(1);
        end
    end

    assign accept_s = |(req_valid & ready_s);

    // Grant, lock, pointer and busy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= {ID_W{1'b0}};
            grant_id_r <= {ID_W{1'b0}};
            locked_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else if (accept_s) begin
            ptr_r      <= next_ptr_s;
            grant_id_r <= win_s;
            locked_r   <= ~sel_last_s;
            busy_r     <= 1'b1;
        end else if (done_s) begin
            busy_r     <= 1'b0;
        end
    end

    uart_tx_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .data_byte (sel_byte_s),
        .baud_tick (baud_tick),
`ifdef UART_PARITY_EN
        .parity    (even_parity(sel_byte_s)),
`endif
        .tx        (tx_s),
        .done      (done_s)
    );

    assign req_ready = ready_s;
    assign tx        = tx_s;
    assign busy      = busy_r;
    assign locked    = locked_r;
    assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a tick-sampled UART receiver and
// an accept monitor feed queues that each scenario compares against the
// expected frames it pushed while driving stimulus.
module tb_uart_tx_arbiter;

`ifdef UART_PARITY_EN
    localparam int NT  = 12;
    localparam bit PAR = 1'b1;
`else
    localparam int NT  = 11;
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        baud_tick;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic        locked;
    logic [0:0]  grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_cnt = 0;

    typedef struct { int id; logic [7:0] data; logic lock; } exp_t;
    typedef struct { int rid; int gid; logic lock; int t; } acc_t;
    typedef struct { logic [7:0] data; logic par; logic stop; } rx_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    rx_t  rx_q[$];

    logic [7:0] s_data [2][4];
    logic       s_last [2][4];
    int         s_n [2];
    int         s_idx [2];
    int         s_gap [2];
    int         s_wait [2];

    uart_tx_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .locked    (locked),
        .grant_id  (grant_id)
    );

    initial forever #5 clk = ~clk;

    // Baud tick: one clk high every 4 clks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick_cnt  = (tick_cnt == 3) ? 0 : tick_cnt + 1;
            baud_tick = (tick_cnt == 3);
        end
    end

    // Accept monitor: records requester, grant_id and lock after each accept.
    logic acc_pend = 1'b0;
    int   acc_rid  = 0;
    always @(negedge clk) begin
        if (acc_pend) begin
            acc_q.push_back('{acc_rid, int'(grant_id), locked, cyc});
            acc_pend = 1'b0;
        end
        if (!rst && ((req_valid & req_ready) != 2'b00)) begin
            acc_pend = 1'b1;
            acc_rid  = (req_ready == 2'b01) ? 0 : ((req_ready == 2'b10) ? 1 : 9);
        end
    end

    // UART receiver sampling tx once per bit period, just before each tick.
    int         rx_st  = 0;
    int         rx_n   = 0;
    logic [7:0] rx_sh  = 8'h00;
    logic       rx_par = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rx_st = 0;
        end else if (baud_tick) begin
            case (rx_st)
                0: if (tx == 1'b0) begin rx_st = 1; rx_n = 0; end
                1: begin
                    rx_sh[rx_n] = tx;
                    rx_n++;
                    if (rx_n == 8) rx_st = PAR ? 2 : 3;
                end
                2: begin rx_par = tx; rx_st = 3; end
                default: begin rx_q.push_back('{rx_sh, rx_par, tx}); rx_st = 0; end
            endcase
        end
    end

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete(); acc_q.delete(); rx_q.delete();
    endtask

    // Drives both requesters from s_* tables until 'frames' bytes arrive.
    task automatic run_streams(input int frames, input int budget);
        int c;
        logic [1:0] acc;
        c = 0;
        s_idx = '{0, 0};
        s_wait = '{0, 0};
        while ((rx_q.size() < frames) && (c < budget)) begin
            for (int i = 0; i < 2; i++) begin
                if ((s_idx[i] < s_n[i]) && (s_wait[i] == 0)) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = s_data[i][s_idx[i]];
                    req_last[i] = s_last[i][s_idx[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #2;
            c++;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    s_idx[i]++;
                    s_wait[i] = s_gap[i];
                end else if (s_wait[i] > 0) begin
                    s_wait[i]--;
                end
            end
        end
        req_valid = 2'b00;
        checks++;
        if (rx_q.size() < frames) begin
            failures++;
            $display("FAIL run_streams: %0d frames received, required %0d within %0d cycles", rx_q.size(), frames, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; req_last = 2'b11; req_data = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 || grant_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b locked=%b grant_id=%0d, required 1 0 0 0", tx, busy, locked, grant_id);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: req_ready=%b, required 00", req_ready);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: req_ready=%b busy=%b, required 00 0", req_ready, busy);
        end
    endtask

    // One byte from requester 0; align=1 places the accept on a tick cycle.
    task automatic test_single_byte(input logic [7:0] d, input bit align);
        int n, tb, errs_tx, errs_busy;
        logic exp_tx, exp_busy;
        exp_t e; rx_t r; acc_t a;
        do_reset();
        n = 0;
        while (align && (baud_tick !== 1'b1) && (n < 8)) begin
            @(posedge clk);
            #2;
            n++;
        end
        req_data[7:0] = d; req_last = 2'b01; req_valid = 2'b01;
        exp_q.push_back('{0, d, 1'b0});
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL ready_pulse: req_ready=%b, required 01", req_ready);
        end
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        tb = 0; errs_tx = 0; errs_busy = 0;
        for (int k = 0; k < NT*4 + 6; k++) begin
            @(negedge clk);
            if (tb == 0) exp_tx = 1'b1;
            else if (tb == 1) exp_tx = 1'b0;
            else if (tb <= 9) exp_tx = d[tb-2];
            else if (tb == 10 && PAR) exp_tx = ^d;
            else exp_tx = 1'b1;
            exp_busy = (tb < NT);
            if (tx !== exp_tx) errs_tx++;
            if (busy !== exp_busy) errs_busy++;
            if (baud_tick) tb++;
        end
        checks++;
        if (errs_tx != 0) begin
            failures++;
            $display("FAIL tx_waveform: byte %h align=%0d, %0d cycles wrong, required 0", d, align, errs_tx);
        end
        checks++;
        if (errs_busy != 0) begin
            failures++;
            $display("FAIL busy_window: byte %h, %0d cycles wrong, required 0", d, errs_busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0 || acc_q.size() == 0) begin
                failures++;
                $display("FAIL sb_missing: byte %h from req %0d not observed", e.data, e.id);
            end else begin
                r = rx_q.pop_front(); a = acc_q.pop_front();
                if (r.data !== e.data || r.stop !== 1'b1 || (PAR && r.par !== ^e.data) ||
                    a.rid != e.id || a.gid != e.id || a.lock !== e.lock) begin
                    failures++;
                    $display("FAIL sb_frame: got data=%h stop=%b par=%b req=%0d grant=%0d lock=%b, required data=%h stop=1 par=%b req=%0d grant=%0d lock=%b",
                             r.data, r.stop, r.par, a.rid, a.gid, a.lock, e.data, ^e.data, e.id, e.id, e.lock);
                end
            end
        end
        checks++;
        if (acc_q.size() != 0) begin
            failures++;
            $display("FAIL accept_once: %0d extra accepts, required 0", acc_q.size());
        end
    endtask

    task automatic test_round_robin();
        exp_t e; rx_t r; acc_t a;
        int k, prev_t;
        do_reset();
        s_n = '{2, 2}; s_gap = '{0, 0};
        s_data[0][0] = 8'h3C; s_data[0][1] = 8'h81; s_last[0][0] = 1'b1; s_last[0][1] = 1'b1;
        s_data[1][0] = 8'hC3; s_data[1][1] = 8'h7E; s_last[1][0] = 1'b1; s_last[1][1] = 1'b1;
        exp_q.push_back('{0, 8'h3C, 1'b0}); exp_q.push_back('{1, 8'hC3, 1'b0});
        exp_q.push_back('{0, 8'h81, 1'b0}); exp_q.push_back('{1, 8'h7E, 1'b0});
        run_streams(4, 4*NT*4 + 60);
        k = 0; prev_t = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0 || acc_q.size() == 0) begin
                failures++;
                $display("FAIL rr_missing: byte %h from req %0d not observed", e.data, e.id);
            end else begin
                r = rx_q.pop_front(); a = acc_q.pop_front();
                if (r.data !== e.data || r.stop !== 1'b1 || (PAR && r.par !== ^e.data) ||
                    a.rid != e.id || a.gid != e.id || a.lock !== e.lock) begin
                    failures++;
                    $display("FAIL rr_frame: got data=%h req=%0d grant=%0d lock=%b, required data=%h req=%0d grant=%0d lock=%b",
                             r.data, a.rid, a.gid, a.lock, e.data, e.id, e.id, e.lock);
                end
                if (k >= 2) begin
                    checks++;
                    if (a.t - prev_t != NT*4) begin
                        failures++;
                        $display("FAIL rr_spacing: accept gap %0d clk, required %0d", a.t - prev_t, NT*4);
                    end
                end
                prev_t = a.t;
            end
            k++;
        end
    endtask

    task automatic test_packet_lock();
        exp_t e; rx_t r; acc_t a;
        do_reset();
        s_n = '{3, 1}; s_gap = '{NT*4 + 24, 0};
        s_data[0][0] = 8'h11; s_data[0][1] = 8'h22; s_data[0][2] = 8'h33;
        s_last[0][0] = 1'b0;  s_last[0][1] = 1'b0;  s_last[0][2] = 1'b1;
        s_data[1][0] = 8'h44; s_last[1][0] = 1'b1;
        exp_q.push_back('{0, 8'h11, 1'b1}); exp_q.push_back('{0, 8'h22, 1'b1});
        exp_q.push_back('{0, 8'h33, 1'b0}); exp_q.push_back('{1, 8'h44, 1'b0});
        run_streams(4, 4*(NT*4 + 30) + 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0 || acc_q.size() == 0) begin
                failures++;
                $display("FAIL lock_missing: byte %h from req %0d not observed", e.data, e.id);
            end else begin
                r = rx_q.pop_front(); a = acc_q.pop_front();
                if (r.data !== e.data || r.stop !== 1'b1 || a.rid != e.id || a.gid != e.id || a.lock !== e.lock) begin
                    failures++;
                    $display("FAIL lock_frame: got data=%h req=%0d grant=%0d lock=%b, required data=%h req=%0d grant=%0d lock=%b",
                             r.data, a.rid, a.gid, a.lock, e.data, e.id, e.id, e.lock);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n, c;
        exp_t e; rx_t r; acc_t a;
        do_reset();
        req_data[7:0] = 8'h96; req_last = 2'b00; req_valid = 2'b01;
        c = 0;
        @(negedge clk);
        while (req_ready[0] !== 1'b1 && c < 8) begin @(negedge clk); c++; end
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        n = 0; c = 0;
        while (n < 5 && c < 40) begin
            @(negedge clk);
            if (baud_tick) n++;
            c++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (locked !== 1'b1 || busy !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset: locked=%b busy=%b tx=%b, required 1 1 0", locked, busy, tx);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 || grant_id !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b busy=%b locked=%b grant_id=%0d, required 1 0 0 0", tx, busy, locked, grant_id);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete(); acc_q.delete(); rx_q.delete();
        s_n = '{1, 1}; s_gap = '{0, 0};
        s_data[0][0] = 8'h5A; s_last[0][0] = 1'b1;
        s_data[1][0] = 8'h99; s_last[1][0] = 1'b1;
        exp_q.push_back('{0, 8'h5A, 1'b0}); exp_q.push_back('{1, 8'h99, 1'b0});
        run_streams(2, 2*NT*4 + 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0 || acc_q.size() == 0) begin
                failures++;
                $display("FAIL post_reset_missing: byte %h from req %0d not observed", e.data, e.id);
            end else begin
                r = rx_q.pop_front(); a = acc_q.pop_front();
                if (r.data !== e.data || r.stop !== 1'b1 || a.rid != e.id || a.gid != e.id || a.lock !== e.lock) begin
                    failures++;
                    $display("FAIL post_reset_frame: got data=%h req=%0d grant=%0d lock=%b, required data=%h req=%0d grant=%0d lock=%b",
                             r.data, a.rid, a.gid, a.lock, e.data, e.id, e.id, e.lock);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0000;
        test_reset();
        test_single_byte(8'hA5, 1'b0);
        test_single_byte(8'h07, 1'b0);
        test_round_robin();
        test_packet_lock();
        test_reset_midframe();
        test_single_byte(8'hC3, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
